// File: rtl/pipe_lzc_norm.sv
// Streaming leading-zero / leading-one / sign-bit counter with left normaliser.
// Count is resolved ahead of slot 1; the barrel shift is applied entering slot 2 (slot 1 when STAGES == 1).
module pipe_lzc_norm #(
    parameter int SIZE     = 64,
    parameter int OUT_SIZE = $clog2(SIZE + 1),
    parameter int STAGES   = 2,
    parameter int TAG_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     din,
    input  logic [1:0]          mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] cnt,
    output logic [SIZE-1:0]     norm,
    output logic                zero,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int LEVELS  = ($clog2(SIZE) + 1) / 2;
    localparam int P       = 1 << (2 * LEVELS);
    localparam int CW      = 2 * LEVELS;
    localparam int SH_SLOT = (STAGES >= 2) ? 2 : 1;

    // 4-way priority tree; returns {found, position of first 1 counted from the MSB}.
    function automatic logic [CW:0] lzc_tree(input logic [P-1:0] w);
        logic [P-1:0]  v;
        logic [P-1:0]  v_n;
        logic [CW-1:0] p   [P];
        logic [CW-1:0] p_n [P];
        logic          found_g;
        v = w;
        for (int i = 0; i < P; i++) p[i] = '0;
        for (int l = 0; l < LEVELS; l++) begin
            v_n = '0;
            for (int i = 0; i < P; i++) p_n[i] = '0;
            for (int g = 0; g < (P >> (2 * (l + 1))); g++) begin
                found_g = 1'b0;
                for (int j = 3; j >= 0; j--) begin
                    if (!found_g && v[4*g+j]) begin
                        found_g = 1'b1;
                        p_n[g]  = CW'((3 - j) << (2 * l)) + p[4*g+j];
                    end else begin
                        found_g = found_g;
                    end
                end
                v_n[g] = found_g;
            end
            v = v_n;
            p = p_n;
        end
        return {v[0], p[0]};
    endfunction

    function automatic logic [SIZE-1:0] barrel(input logic [SIZE-1:0] d, input logic [OUT_SIZE-1:0] sh);
        logic [SIZE-1:0] r;
        r = d;
        for (int b = 0; b < OUT_SIZE; b++) begin
            if (sh[b]) r = r << (1 << b);
            else       r = r;
        end
        return r;
    endfunction

    logic [SIZE-1:0]     srch_s;
    logic [P-1:0]        pad_s;
    logic [OUT_SIZE-1:0] lim_s;
    logic [CW:0]         tree_s;
    logic [OUT_SIZE-1:0] cnt0_s;
    logic                zero0_s;

    // CLS searches the bits below the MSB for the first one differing from the sign.
    always_comb begin
        case (mode)
            2'b01: begin
                srch_s = ~din;
                lim_s  = OUT_SIZE'(SIZE);
            end
            2'b10: begin
                srch_s = {din[SIZE-2:0] ^ {(SIZE-1){din[SIZE-1]}}, 1'b0};
                lim_s  = OUT_SIZE'(SIZE - 1);
            end
            default: begin
                srch_s = din;
                lim_s  = OUT_SIZE'(SIZE);
            end
        endcase
        pad_s  = P'(srch_s) << (P - SIZE);
        tree_s = lzc_tree(pad_s);
        if (!tree_s[CW] || (int'(tree_s[CW-1:0]) >= int'(lim_s))) begin
            cnt0_s  = lim_s;
            zero0_s = 1'b1;
        end else begin
            cnt0_s  = OUT_SIZE'(tree_s[CW-1:0]);
            zero0_s = 1'b0;
        end
    end

    logic [STAGES:1]                v_q, v_d;
    logic [STAGES:1][SIZE-1:0]      dat_q, dat_d;
    logic [STAGES:1][OUT_SIZE-1:0]  cnt_q, cnt_d;
    logic [STAGES:1]                zero_q, zero_d;
    logic [STAGES:1][TAG_W-1:0]     tag_q, tag_d;
    logic [STAGES:1]                rdy_s;

    // Index 0 is the incoming word, indices 1..STAGES are the slot registers.
    logic [STAGES:0]                v_s;
    logic [STAGES:0][SIZE-1:0]      dat_s;
    logic [STAGES:0][OUT_SIZE-1:0]  cnt_s;
    logic [STAGES:0]                zero_s;
    logic [STAGES:0][TAG_W-1:0]     tag_s;

    assign v_s    = {v_q, in_valid};
    assign dat_s  = {dat_q, din};
    assign cnt_s  = {cnt_q, cnt0_s};
    assign zero_s = {zero_q, zero0_s};
    assign tag_s  = {tag_q, in_tag};

    // Backward ready chain: a slot can load when empty or when its successor moves.
    always_comb begin
        rdy_s[STAGES] = out_ready | ~v_q[STAGES];
        for (int k = STAGES - 1; k >= 1; k--) begin
            rdy_s[k] = ~v_q[k] | rdy_s[k+1];
        end
    end

    assign in_ready = rdy_s[1] & ~rst;

    // Slot advance; payload only loads with a valid word so stalled outputs hold.
    always_comb begin
        v_d    = v_q;
        dat_d  = dat_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        tag_d  = tag_q;
        for (int k = 1; k <= STAGES; k++) begin
            if (rdy_s[k]) begin
                v_d[k] = v_s[k-1];
                if (v_s[k-1]) begin
                    dat_d[k]  = (k == SH_SLOT) ? barrel(dat_s[k-1], cnt_s[k-1]) : dat_s[k-1];
                    cnt_d[k]  = cnt_s[k-1];
                    zero_d[k] = zero_s[k-1];
                    tag_d[k]  = tag_s[k-1];
                end else begin
                    dat_d[k] = dat_q[k];
                end
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // Slot registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            dat_q  <= '0;
            cnt_q  <= '0;
            zero_q <= '0;
            tag_q  <= '0;
        end else begin
            v_q    <= v_d;
            dat_q  <= dat_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            tag_q  <= tag_d;
        end
    end

    assign out_valid = v_s[STAGES];
    assign cnt       = cnt_s[STAGES];
    assign norm      = dat_s[STAGES];
    assign zero      = zero_s[STAGES];
    assign out_tag   = tag_s[STAGES];

endmodule

// File: tb/tb_pipe_lzc_norm.sv
// Directed and scoreboard bench for pipe_lzc_norm (SIZE=64/STAGES=2 and SIZE=10/STAGES=1).
module tb_pipe_lzc_norm;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [63:0] din, norm;
    logic [1:0]  mode;
    logic [3:0]  in_tag, out_tag;
    logic [6:0]  cnt;

    logic        in_valid10, in_ready10, out_valid10, out_ready10, zero10;
    logic [9:0]  din10, norm10;
    logic [1:0]  mode10;
    logic [3:0]  tag10, out_tag10;
    logic [3:0]  cnt10;

    int checks;
    int errors;
    int sent;
    int got;

    typedef struct {
        logic [6:0]  c;
        logic [63:0] n;
        logic        z;
        logic [3:0]  t;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [63:0] r;
    logic [1:0]  m;
    int          rc;

    pipe_lzc_norm #(.SIZE(64), .STAGES(2), .TAG_W(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .mode(mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .cnt(cnt), .norm(norm), .zero(zero), .out_tag(out_tag)
    );

    pipe_lzc_norm #(.SIZE(10), .STAGES(1), .TAG_W(4)) u10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .din(din10),
        .mode(mode10), .in_tag(tag10), .out_valid(out_valid10), .out_ready(out_ready10),
        .cnt(cnt10), .norm(norm10), .zero(zero10), .out_tag(out_tag10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [63:0] d, input logic [1:0] md,
                       input logic [3:0] t, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        din       = d;
        mode      = md;
        in_tag    = t;
        out_ready = ordy;
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [6:0] c, input logic [63:0] n,
                           input logic z, input logic [3:0] t);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_cnt"}, cnt, c);
        chk({nm, "_norm"}, norm, n);
        chk({nm, "_zero"}, zero, z);
        chk({nm, "_tag"}, out_tag, t);
    endtask

    task automatic chk_out10(input string nm, input logic [3:0] c, input logic [9:0] n,
                             input logic z, input logic [3:0] t);
        chk({nm, "_valid"}, out_valid10, 1'b1);
        chk({nm, "_cnt"}, cnt10, c);
        chk({nm, "_norm"}, norm10, n);
        chk({nm, "_zero"}, zero10, z);
        chk({nm, "_tag"}, out_tag10, t);
    endtask

    // Bit-serial reference count.
    function automatic int ref_cnt(input logic [63:0] d, input logic [1:0] md);
        int   c;
        logic going;
        logic b;
        c     = 0;
        going = 1'b1;
        if (md == 2'b10) begin
            for (int i = 62; i >= 0; i--) begin
                if (going && (d[i] == d[63])) c++;
                else going = 1'b0;
            end
        end else begin
            b = (md == 2'b01);
            for (int i = 63; i >= 0; i--) begin
                if (going && (d[i] == b)) c++;
                else going = 1'b0;
            end
        end
        return c;
    endfunction

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        in_valid = 1'b0; din = '0; mode = 2'b00; in_tag = '0; out_ready = 1'b1;
        in_valid10 = 1'b0; din10 = '0; mode10 = 2'b00; tag10 = '0; out_ready10 = 1'b1;

        // Reset state
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", cnt, 7'd0);
        chk("rst_norm", norm, 64'h0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_tag", out_tag, 4'h0);
        chk("rst_valid10", out_valid10, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);

        // Single word, latency 2
        drv(1'b1, 64'h0000_0000_0001_0000, 2'b00, 4'd3, 1'b1);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("t1_latency", out_valid, 1'b0);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("t1", 7'd47, 64'h8000_0000_0000_0000, 1'b0, 4'd3);

        // Back-to-back LZ/LO
        drv(1'b1, 64'h0, 2'b00, 4'd1, 1'b1);
        drv(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 4'd2, 1'b1);
        drv(1'b1, 64'hF000_0000_0000_00AB, 2'b01, 4'd3, 1'b1);
        chk_out("b2b0", 7'd64, 64'h0, 1'b1, 4'd1);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("b2b1", 7'd64, 64'h0, 1'b1, 4'd2);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("b2b2", 7'd4, 64'h0000_0000_0000_0AB0, 1'b0, 4'd3);

        // CLS and reserved mode
        drv(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 2'b10, 4'd4, 1'b1);
        drv(1'b1, 64'h0000_0000_0000_0001, 2'b10, 4'd5, 1'b1);
        drv(1'b1, 64'h0, 2'b10, 4'd6, 1'b1);
        chk_out("cls0", 7'd55, 64'h8000_0000_0000_0000, 1'b0, 4'd4);
        drv(1'b1, 64'h0000_0000_0001_0000, 2'b11, 4'd7, 1'b1);
        chk_out("cls1", 7'd62, 64'h4000_0000_0000_0000, 1'b0, 4'd5);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("cls2", 7'd63, 64'h0, 1'b1, 4'd6);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("mode11", 7'd47, 64'h8000_0000_0000_0000, 1'b0, 4'd7);

        // Backpressure: 6 stalled cycles with continuous input
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            drv(sent < 10, 64'h8000_0000_0000_0000 >> sent, 2'b00, 4'(sent), 1'b0);
            chk("bp_in_ready", in_ready, (c < 2));
            if (c >= 2) chk_out("bp_hold", 7'd0, 64'h8000_0000_0000_0000, 1'b0, 4'd0);
            if (in_valid && in_ready) sent++;
        end
        chk("bp_accepts", sent, 2);
        got = 0;
        for (int c = 0; c < 20 && got < 10; c++) begin
            drv(sent < 10, 64'h8000_0000_0000_0000 >> sent, 2'b00, 4'(sent), 1'b1);
            chk("bp_gap", out_valid, 1'b1);
            if (out_valid) begin
                chk("bp_tag", out_tag, got);
                chk("bp_cnt", cnt, got);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_done", got, 10);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);

        // Random traffic against the reference model
        sent = 0; got = 0; sb.delete();
        for (int c = 0; c < 40000 && got < 10000; c++) begin
            r = {$urandom, $urandom} >> $urandom_range(0, 64);
            if ($urandom_range(0, 1) == 1) r = ~r;
            m = 2'($urandom_range(0, 3));
            drv((sent < 10000) && ($urandom_range(0, 3) != 0), r, m, 4'(sent),
                ($urandom_range(0, 2) != 0));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", (sb.size() != 0), 1'b1);
                end else begin
                    e = sb.pop_front();
                    chk("sb", {cnt, zero, out_tag, norm}, {e.c, e.z, e.t, e.n});
                end
                got++;
            end
            if (in_valid && in_ready) begin
                rc  = ref_cnt(din, mode);
                e.c = 7'(rc);
                e.z = (mode == 2'b10) ? (rc == 63) : (rc == 64);
                e.n = din << rc;
                e.t = in_tag;
                sb.push_back(e);
                sent++;
            end
        end
        chk("sb_count", got, 10000);
        chk("sb_left", sb.size(), 0);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);

        // Reset with two words in flight
        drv(1'b1, 64'h1, 2'b00, 4'hA, 1'b0);
        drv(1'b1, 64'h2, 2'b00, 4'hB, 1'b0);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("rs_inflight", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_async", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("rs_nostale", out_valid, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        drv(1'b1, 64'h0000_0000_0000_1000, 2'b00, 4'd7, 1'b1);
        chk("rs_nostale2", out_valid, 1'b0);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk("rs_latency", out_valid, 1'b0);
        drv(1'b0, 64'h0, 2'b00, 4'h0, 1'b1);
        chk_out("rs_new", 7'd51, 64'h8000_0000_0000_0000, 1'b0, 4'd7);

        // SIZE=10, STAGES=1
        @(negedge clk);
        in_valid10 = 1'b1; din10 = 10'b00_0000_0100; mode10 = 2'b00; tag10 = 4'd1; #1;
        @(negedge clk);
        din10 = 10'h000; mode10 = 2'b00; tag10 = 4'd2; #1;
        chk_out10("s10_lz", 4'd7, 10'b10_0000_0000, 1'b0, 4'd1);
        @(negedge clk);
        din10 = 10'b11_1111_0000; mode10 = 2'b10; tag10 = 4'd3; #1;
        chk_out10("s10_zero", 4'd10, 10'h000, 1'b1, 4'd2);
        @(negedge clk);
        din10 = 10'h3FF; mode10 = 2'b01; tag10 = 4'd4; #1;
        chk_out10("s10_cls", 4'd5, 10'b10_0000_0000, 1'b0, 4'd3);
        @(negedge clk);
        in_valid10 = 1'b0; #1;
        chk_out10("s10_lo", 4'd10, 10'h000, 1'b1, 4'd4);
        @(negedge clk);
        #1;
        chk("s10_drain", out_valid10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
